// File: rtl/mult4u_result_checker.sv
// mult4u_result_checker
//   Check stage for the 4-bit unsigned combinational multiplier. Accepts an
//   operand pair plus the multiplier's product in one handshake. It recomputes
//   the product with an independent shift-add datapath, one partial product per
//   cycle. It then presents the reference product and a per-transaction fault
//   flag. A saturating fault counter and a sticky fault flag are maintained.
//
//   Ports
//     clk, rst_n    clock, asynchronous active-low reset
//     in_valid/in_ready   operand/product triple handshake (ready in IDLE only)
//     a, b, p_dut   operands and product under check
//     out_valid/out_ready result handshake
//     p_out         reference product
//     fault         p_dut differs from the reference
//     fault_any     sticky fault flag
//     fault_count   saturating fault counter
//     clr_count     synchronous clear of fault_count and fault_any
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a triple, in_ready=1
//   CALC  | shift-add, one bit of b_q per cycle, WIDTH cycles
//   DONE  | result presented, held until out_ready

module mult4u_result_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] p_dut,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p_out,
    output logic               fault,
    output logic               fault_any,
    output logic [CNT_W-1:0]   fault_count,
    input  logic               clr_count
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0]    STEP_LAST = SW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] p_dut_q;
    logic [2*WIDTH-1:0] acc;
    logic [SW-1:0]      step;

    logic               accept;
    logic               done_hs;
    logic               last_step;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_sum;

    assign accept    = in_valid && in_ready;
    assign done_hs   = out_valid && out_ready;
    assign last_step = (step == STEP_LAST);
    assign partial   = b_q[step] ? ({{WIDTH{1'b0}}, a_q} << step) : '0;
    assign acc_sum   = acc + partial;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_CALC;
            S_CALC: if (last_step) state_nxt = S_DONE;
            S_DONE: if (done_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: in_ready  = 1'b1;
            S_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture and shift-add datapath. p_out/fault are loaded on the final
    // step so they stay frozen through DONE and after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            p_dut_q <= '0;
            acc     <= '0;
            step    <= '0;
            p_out   <= '0;
            fault   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            p_dut_q <= p_dut;
            acc     <= '0;
            step    <= '0;
        end else if (state == S_CALC) begin
            acc  <= acc_sum;
            step <= step + 1'b1;
            if (last_step) begin
                p_out <= acc_sum;
                fault <= (acc_sum != p_dut_q);
            end
        end
    end

    // Fault statistics: one increment per DONE handshake; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_count <= '0;
            fault_any   <= 1'b0;
        end else if (clr_count) begin
            fault_count <= '0;
            fault_any   <= 1'b0;
        end else if (done_hs && fault) begin
            fault_any <= 1'b1;
            if (fault_count != CNT_MAX) begin
                fault_count <= fault_count + 1'b1;
            end
        end
    end

endmodule
